// File: rtl/barycentric_stepper_if.sv
// Bundle of setup and pixel-stream signals for barycentric_stepper.
// The slave side is the stepper itself; the master side drives setup
// and the downstream ready, and consumes the pixel stream.
interface barycentric_stepper_if;
    logic        nd;
    logic        us_rfd;
    logic [15:0] x_min;
    logic [15:0] x_max;
    logic [15:0] y_min;
    logic [15:0] y_max;
    logic [15:0] u0;
    logic [15:0] v0;
    logic [15:0] w0;
    logic [15:0] du_dx;
    logic [15:0] dv_dx;
    logic [15:0] dw_dx;
    logic [15:0] du_dy;
    logic [15:0] dv_dy;
    logic [15:0] dw_dy;
    logic        ds_rfd;
    logic        rdy;
    logic [15:0] u;
    logic [15:0] v;
    logic [15:0] w;
    logic [15:0] p_x;
    logic [15:0] p_y;
    logic        done;

    modport master (
        output nd, x_min, x_max, y_min, y_max,
        output u0, v0, w0, du_dx, dv_dx, dw_dx, du_dy, dv_dy, dw_dy,
        output ds_rfd,
        input  us_rfd, rdy, u, v, w, p_x, p_y, done
    );

    modport slave (
        input  nd, x_min, x_max, y_min, y_max,
        input  u0, v0, w0, du_dx, dv_dx, dw_dx, du_dy, dv_dy, dw_dy,
        input  ds_rfd,
        output us_rfd, rdy, u, v, w, p_x, p_y, done
    );
endinterface

// File: rtl/barycentric_stepper.sv
// Walks a triangle's bounding box in raster order (x fastest), one pixel
// per accepted transfer, stepping three Q16.8 barycentric accumulators
// incrementally and presenting them as fp16 together with the pixel
// coordinates.
module barycentric_stepper (
    input  logic                  clk,
    input  logic                  rst,
    barycentric_stepper_if.slave  bus
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t            state;
    state_t            state_n;
    logic              us_rfd_q;
    logic              us_rfd_n;
    logic              done_q;
    logic              done_n;
    logic [15:0]       p_x_q;
    logic [15:0]       p_x_n;
    logic [15:0]       p_y_q;
    logic [15:0]       p_y_n;
    logic [15:0]       x_min_q;
    logic [15:0]       x_min_n;
    logic [15:0]       x_max_q;
    logic [15:0]       x_max_n;
    logic [15:0]       y_max_q;
    logic [15:0]       y_max_n;

    // Index 0 = u, 1 = v, 2 = w throughout.
    logic [2:0][23:0]  acc_q;
    logic [2:0][23:0]  acc_n;
    logic [2:0][23:0]  row_q;
    logic [2:0][23:0]  row_n;
    logic [2:0][15:0]  dx_q;
    logic [2:0][15:0]  dx_n;
    logic [2:0][15:0]  dy_q;
    logic [2:0][15:0]  dy_n;

    logic [2:0][15:0]  start_in;
    logic [2:0][15:0]  dx_in;
    logic [2:0][15:0]  dy_in;

    assign start_in = {bus.w0, bus.v0, bus.u0};
    assign dx_in    = {bus.dw_dx, bus.dv_dx, bus.du_dx};
    assign dy_in    = {bus.dw_dy, bus.dv_dy, bus.du_dy};

    function automatic logic [23:0] sext(input logic [15:0] val);
        return {{8{val[15]}}, val};
    endfunction

    // Q16.8 to fp16: exponent follows the leading one of the magnitude,
    // mantissa is the next ten bits below it, truncated. The ten zero
    // bits appended below the magnitude supply the fill when the leading
    // one sits low.
    function automatic logic [15:0] to_fp16(input logic [23:0] val);
        logic [23:0] mag;
        logic [33:0] ext;
        logic [5:0]  lead;
        logic [4:0]  expo;
        logic [9:0]  mant;
        mag  = val[23] ? (~val + 24'd1) : val;
        lead = 6'd0;
        for (int i = 0; i < 24; i++) begin
            if (mag[i]) lead = 6'(i);
        end
        ext  = {mag, 10'b0};
        mant = ext[lead +: 10];
        expo = 5'(lead + 6'd7);
        return (val == 24'd0) ? 16'h0000 : {val[23], expo, mant};
    endfunction

    // Next-state and datapath update: setup acceptance in IDLE, raster
    // stepping on each transfer in SCAN.
    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        p_x_n   = p_x_q;
        p_y_n   = p_y_q;
        x_min_n = x_min_q;
        x_max_n = x_max_q;
        y_max_n = y_max_q;
        acc_n   = acc_q;
        row_n   = row_q;
        dx_n    = dx_q;
        dy_n    = dy_q;
        case (state)
            IDLE: begin
                if (bus.nd && us_rfd_q) begin
                    if ((bus.x_max < bus.x_min) || (bus.y_max < bus.y_min)) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = SCAN;
                        p_x_n   = bus.x_min;
                        p_y_n   = bus.y_min;
                        x_min_n = bus.x_min;
                        x_max_n = bus.x_max;
                        y_max_n = bus.y_max;
                        dx_n    = dx_in;
                        dy_n    = dy_in;
                        for (int i = 0; i < 3; i++) begin
                            acc_n[i] = sext(start_in[i]);
                            row_n[i] = sext(start_in[i]);
                        end
                    end
                end
            end
            SCAN: begin
                if (bus.ds_rfd) begin
                    if (p_x_q < x_max_q) begin
                        p_x_n = p_x_q + 16'd1;
                        for (int i = 0; i < 3; i++) begin
                            acc_n[i] = acc_q[i] + sext(dx_q[i]);
                        end
                    end else if (p_y_q < y_max_q) begin
                        p_x_n = x_min_q;
                        p_y_n = p_y_q + 16'd1;
                        for (int i = 0; i < 3; i++) begin
                            row_n[i] = row_q[i] + sext(dy_q[i]);
                            acc_n[i] = row_n[i];
                        end
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        us_rfd_n = (state_n == IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            us_rfd_q <= 1'b0;
            done_q   <= 1'b0;
            p_x_q    <= 16'd0;
            p_y_q    <= 16'd0;
            x_min_q  <= 16'd0;
            x_max_q  <= 16'd0;
            y_max_q  <= 16'd0;
            acc_q    <= '0;
            row_q    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
        end else begin
            state    <= state_n;
            us_rfd_q <= us_rfd_n;
            done_q   <= done_n;
            p_x_q    <= p_x_n;
            p_y_q    <= p_y_n;
            x_min_q  <= x_min_n;
            x_max_q  <= x_max_n;
            y_max_q  <= y_max_n;
            acc_q    <= acc_n;
            row_q    <= row_n;
            dx_q     <= dx_n;
            dy_q     <= dy_n;
        end
    end

    assign bus.us_rfd = us_rfd_q;
    assign bus.rdy    = (state == SCAN);
    assign bus.done   = done_q;
    assign bus.p_x    = p_x_q;
    assign bus.p_y    = p_y_q;
    assign bus.u      = to_fp16(acc_q[0]);
    assign bus.v      = to_fp16(acc_q[1]);
    assign bus.w      = to_fp16(acc_q[2]);

endmodule

// File: tb/tb_barycentric_stepper.sv
// Testbench for barycentric_stepper: directed and randomized triangles
// compared against a closed-form reference (weight = start + dx*i + dy*j,
// converted to fp16 by arithmetic) pixel by pixel.
module tb_barycentric_stepper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] u;
        logic [15:0] v;
        logic [15:0] w;
    } pix_t;

    pix_t exp_q[$];

    always #5 clk = ~clk;

    barycentric_stepper_if bus();

    barycentric_stepper dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("[TB] FAIL %s observed=%0h required=%0h", tag, obs, expv);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic longint sext16(input logic [15:0] val);
        longint r;
        r = $signed(val);
        return r;
    endfunction

    // Fixed-point value (wrapped to 24-bit two's complement) to fp16,
    // computed from magnitude and floor(log2).
    function automatic logic [15:0] model_fp16(input longint value);
        longint wrapped;
        longint mag;
        longint mant;
        int     e;
        logic   sgn;
        wrapped = value & 64'sh0000_0000_00FF_FFFF;
        if (wrapped >= 64'sh80_0000) wrapped = wrapped - 64'sh100_0000;
        if (wrapped == 0) return 16'h0000;
        sgn = (wrapped < 0);
        mag = sgn ? -wrapped : wrapped;
        e = 0;
        while ((mag >> (e + 1)) != 0) e++;
        mant = ((mag << 10) >> e) - 1024;
        return {sgn, 5'(e + 7), 10'(mant)};
    endfunction

    task automatic build_model(input logic [15:0] xmin, input logic [15:0] xmax,
                               input logic [15:0] ymin, input logic [15:0] ymax,
                               input logic [2:0][15:0] s, input logic [2:0][15:0] dx,
                               input logic [2:0][15:0] dy);
        pix_t   p;
        longint wv [3];
        exp_q.delete();
        for (int y = int'(ymin); y <= int'(ymax); y++) begin
            for (int x = int'(xmin); x <= int'(xmax); x++) begin
                for (int i = 0; i < 3; i++) begin
                    wv[i] = sext16(s[i]) + longint'(x - int'(xmin)) * sext16(dx[i])
                          + longint'(y - int'(ymin)) * sext16(dy[i]);
                end
                p.x = 16'(x);
                p.y = 16'(y);
                p.u = model_fp16(wv[0]);
                p.v = model_fp16(wv[1]);
                p.w = model_fp16(wv[2]);
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic scramble_setup;
        bus.x_min = 16'($urandom);
        bus.x_max = 16'($urandom);
        bus.y_min = 16'($urandom);
        bus.y_max = 16'($urandom);
        bus.u0    = 16'($urandom);
        bus.v0    = 16'($urandom);
        bus.w0    = 16'($urandom);
        bus.du_dx = 16'($urandom);
        bus.dv_dx = 16'($urandom);
        bus.dw_dx = 16'($urandom);
        bus.du_dy = 16'($urandom);
        bus.dv_dy = 16'($urandom);
        bus.dw_dy = 16'($urandom);
    endtask

    // Submit one triangle and follow its pixel stream. stall randomizes
    // ds_rfd, noise pulses nd and scrambles setup during the scan, and a
    // nonzero abort_after asserts rst once that many pixels have moved.
    task automatic run_triangle(input string name,
                                input logic [15:0] xmin, input logic [15:0] xmax,
                                input logic [15:0] ymin, input logic [15:0] ymax,
                                input logic [2:0][15:0] s, input logic [2:0][15:0] dx,
                                input logic [2:0][15:0] dy,
                                input bit stall, input bit noise, input int abort_after);
        int guard;
        int idx;
        int cnt;
        bit degenerate;
        bit xfer;
        guard = 0;
        while (!bus.us_rfd && guard < 100) begin
            tick;
            guard++;
        end
        check({name, " ready for setup"}, 128'(bus.us_rfd), 128'(1));
        degenerate = (xmax < xmin) || (ymax < ymin);
        if (!degenerate) build_model(xmin, xmax, ymin, ymax, s, dx, dy);
        bus.nd     = 1'b1;
        bus.x_min  = xmin;
        bus.x_max  = xmax;
        bus.y_min  = ymin;
        bus.y_max  = ymax;
        bus.u0     = s[0];
        bus.v0     = s[1];
        bus.w0     = s[2];
        bus.du_dx  = dx[0];
        bus.dv_dx  = dx[1];
        bus.dw_dx  = dx[2];
        bus.du_dy  = dy[0];
        bus.dv_dy  = dy[1];
        bus.dw_dy  = dy[2];
        bus.ds_rfd = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        tick;
        bus.nd = 1'b0;
        scramble_setup();
        if (degenerate) begin
            check({name, " degenerate accept rdy/done/us_rfd"},
                  128'({bus.rdy, bus.done, bus.us_rfd}), 128'(3'b011));
            tick;
            check({name, " degenerate after rdy/done/us_rfd"},
                  128'({bus.rdy, bus.done, bus.us_rfd}), 128'(3'b001));
            return;
        end
        idx   = 0;
        guard = 0;
        cnt   = exp_q.size();
        while (idx < cnt && guard < 20 * cnt + 50) begin
            check($sformatf("%s pixel %0d", name, idx),
                  128'({bus.rdy, bus.done, bus.us_rfd, bus.p_x, bus.p_y, bus.u, bus.v, bus.w}),
                  128'({3'b100, exp_q[idx].x, exp_q[idx].y, exp_q[idx].u, exp_q[idx].v, exp_q[idx].w}));
            if (abort_after != 0 && idx == abort_after) begin
                bus.nd = 1'b0;
                rst    = 1'b1;
                tick;
                check({name, " abort rdy/done/us_rfd"},
                      128'({bus.rdy, bus.done, bus.us_rfd}), 128'(3'b000));
                rst = 1'b0;
                tick;
                check({name, " post-abort rdy/done/us_rfd"},
                      128'({bus.rdy, bus.done, bus.us_rfd}), 128'(3'b001));
                return;
            end
            bus.ds_rfd = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) begin
                bus.nd = 1'($urandom_range(0, 1));
                scramble_setup();
            end
            xfer = bus.ds_rfd;
            tick;
            guard++;
            if (xfer) idx++;
        end
        bus.nd = 1'b0;
        check({name, " pixel count"}, 128'(idx), 128'(cnt));
        check({name, " end rdy/done/us_rfd"},
              128'({bus.rdy, bus.done, bus.us_rfd}), 128'(3'b011));
        tick;
        check({name, " after end rdy/done/us_rfd"},
              128'({bus.rdy, bus.done, bus.us_rfd}), 128'(3'b001));
    endtask

    initial begin
        logic [2:0][15:0] s;
        logic [2:0][15:0] dx;
        logic [2:0][15:0] dy;
        logic [15:0]      x0;
        logic [15:0]      y0;

        bus.nd     = 1'b0;
        bus.ds_rfd = 1'b0;
        scramble_setup();

        // Reset held four cycles, then released.
        rst = 1'b1;
        repeat (4) tick;
        check("reset outputs",
              128'({bus.us_rfd, bus.rdy, bus.done, bus.u, bus.v, bus.w, bus.p_x, bus.p_y}),
              128'(0));
        rst = 1'b0;
        tick;
        check("us_rfd after release", 128'({bus.us_rfd, bus.rdy, bus.done}), 128'(3'b100));

        // Single-pixel conversions.
        dx = '0;
        dy = '0;
        s  = {16'hFF00, 16'h0100, 16'h0080};
        run_triangle("conv a", 16'd5, 16'd5, 16'd9, 16'd9, s, dx, dy, 1'b0, 1'b0, 0);
        s  = {16'h0000, 16'h0001, 16'h00C0};
        run_triangle("conv b", 16'd0, 16'd0, 16'd0, 16'd0, s, dx, dy, 1'b0, 1'b0, 0);
        s  = {16'h8000, 16'h7FFF, 16'h0000};
        run_triangle("conv c", 16'd3, 16'd3, 16'd1, 16'd1, s, dx, dy, 1'b0, 1'b0, 0);

        // Two-row scan, full throughput.
        s  = {16'h0100, 16'hFF80, 16'h0000};
        dx = {16'hFFC0, 16'h0020, 16'h0040};
        dy = {16'h0200, 16'hFF00, 16'h0100};
        run_triangle("scan", 16'd2, 16'd4, 16'd7, 16'd8, s, dx, dy, 1'b0, 1'b0, 0);

        // Same scan under backpressure with nd noise.
        run_triangle("stall", 16'd2, 16'd4, 16'd7, 16'd8, s, dx, dy, 1'b1, 1'b1, 0);

        // Degenerate boxes.
        run_triangle("degen x", 16'd6, 16'd5, 16'd1, 16'd4, s, dx, dy, 1'b0, 1'b0, 0);
        run_triangle("degen y", 16'd1, 16'd5, 16'd9, 16'd2, s, dx, dy, 1'b0, 1'b0, 0);

        // Abort after three transfers, then a fresh triangle.
        run_triangle("abort", 16'd2, 16'd4, 16'd7, 16'd8, s, dx, dy, 1'b0, 1'b0, 3);
        s  = {16'h0040, 16'h0300, 16'hFE00};
        dx = {16'h0010, 16'hFFF0, 16'h0100};
        dy = {16'h0001, 16'h0080, 16'hFF00};
        run_triangle("fresh", 16'd10, 16'd12, 16'd20, 16'd22, s, dx, dy, 1'b0, 1'b0, 0);

        // Randomized triangles under random backpressure and noise.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 3; i++) begin
                s[i]  = 16'($urandom);
                dx[i] = 16'($urandom);
                dy[i] = 16'($urandom);
            end
            x0 = 16'($urandom_range(0, 1000));
            y0 = 16'($urandom_range(0, 1000));
            run_triangle($sformatf("rand %0d", t), x0, x0 + 16'($urandom_range(0, 4)),
                         y0, y0 + 16'($urandom_range(0, 3)), s, dx, dy, 1'b1, 1'b1, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
